// File: rtl/usb_tx_seq.sv
// usb_tx_seq: USB transmit sequencer stepping a bit shifter through token, data and handshake packets.
// Define USB_TX_HANDSHAKE_EN to append the ACK handshake packet; otherwise done follows the data packet.
module usb_tx_seq #(
  parameter int DATA_BYTES = 8,
  parameter int EOP_CYCLES = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic [3:0] token_pid,
  input  logic       abort,
  input  logic       field_done,
  output logic       busy,
  output logic [2:0] field_sel,
  output logic       load_en,
  output logic [7:0] pid_out,
  output logic [5:0] byte_idx,
  output logic       data_toggle,
  output logic       done
);

  typedef enum logic [3:0] {
    IDLE, TOK_SYNC, TOK_PID, TOK_CRC5, TOK_EOP, TOK_GAP,
    DAT_SYNC, DAT_PID, DAT_BYTES, DAT_CRC16, DAT_EOP, DAT_GAP,
    HS_SYNC, HS_PID, HS_EOP, HS_GAP
  } state_t;

  localparam logic [3:0] EOP_LOAD  = 4'(EOP_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES - 1);
  localparam logic [5:0] LAST_BYTE = 6'(DATA_BYTES - 1);
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;

`ifdef USB_TX_HANDSHAKE_EN
  localparam state_t LAST_GAP = HS_GAP;
`else
  localparam state_t LAST_GAP = DAT_GAP;
`endif

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] byte_q, byte_d;
  logic       toggle_q, toggle_d;
  logic       first_q, first_d;
  logic [3:0] tok_pid_q, tok_pid_d;

  logic       is_field;
  logic       is_timed;
  logic [3:0] pid;

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    toggle_d  = toggle_q;
    first_d   = 1'b0;
    tok_pid_d = tok_pid_q;
    field_sel = 3'd0;
    pid       = 4'd0;
    is_field  = 1'b0;
    is_timed  = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      IDLE: ;
      TOK_SYNC, DAT_SYNC, HS_SYNC: begin field_sel = 3'd1; is_field = 1'b1; end
      TOK_PID:   begin field_sel = 3'd2; is_field = 1'b1; pid = tok_pid_q; end
      DAT_PID:   begin field_sel = 3'd2; is_field = 1'b1; pid = toggle_q ? PID_DATA1 : PID_DATA0; end
      HS_PID:    begin field_sel = 3'd2; is_field = 1'b1; pid = PID_ACK; end
      TOK_CRC5:  begin field_sel = 3'd3; is_field = 1'b1; end
      DAT_BYTES: begin field_sel = 3'd4; is_field = 1'b1; end
      DAT_CRC16: begin field_sel = 3'd5; is_field = 1'b1; end
      TOK_EOP, DAT_EOP, HS_EOP: begin field_sel = 3'd6; is_timed = 1'b1; end
      default:   is_timed = 1'b1;
    endcase

    if (state_q == IDLE) begin
      if (start) begin
        state_d   = TOK_SYNC;
        tok_pid_d = token_pid;
      end
    end else if (is_field) begin
      // The load cycle is owned by the shifter, so a field_done seen there is stale.
      if (field_done && !first_q) begin
        if (state_q == DAT_BYTES && byte_q != LAST_BYTE) begin
          byte_d  = byte_q + 6'd1;
          first_d = 1'b1;
        end else begin
          state_d = state_t'(state_q + 4'd1);
          byte_d  = 6'd0;
        end
      end
    end else if (is_timed) begin
      if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else if (state_q == LAST_GAP) begin
        state_d  = IDLE;
        done     = 1'b1;
        toggle_d = ~toggle_q;
      end else begin
        state_d = state_t'(state_q + 4'd1);
      end
    end

    // Every entry into a state reloads the hold counter and marks the field's load cycle.
    if (state_d != state_q) begin
      first_d = (state_d != IDLE);
      unique case (state_d)
        TOK_EOP, DAT_EOP, HS_EOP: cnt_d = EOP_LOAD;
        TOK_GAP, DAT_GAP, HS_GAP: cnt_d = GAP_LOAD;
        default:                  cnt_d = 4'd0;
      endcase
    end

    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      cnt_d    = 4'd0;
      byte_d   = 6'd0;
      toggle_d = toggle_q;
      first_d  = 1'b0;
      done     = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      byte_q    <= 6'd0;
      toggle_q  <= 1'b0;
      first_q   <= 1'b0;
      tok_pid_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      byte_q    <= byte_d;
      toggle_q  <= toggle_d;
      first_q   <= first_d;
      tok_pid_q <= tok_pid_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign load_en     = is_field & first_q;
  assign pid_out     = (field_sel == 3'd2) ? {~pid, pid} : 8'h00;
  assign byte_idx    = byte_q;
  assign data_toggle = toggle_q;

endmodule

// File: tb/tb_usb_tx_seq.sv
// tb_usb_tx_seq: scoreboard bench for usb_tx_seq; expected PIDs, byte indices and toggle values are
// queued when each transaction is launched and retired by a negedge monitor as the DUT emits them.
`timescale 1ns/1ps
module tb_usb_tx_seq;
  localparam int N  = 8, E  = 2, G  = 2;
  localparam int SN = 1, SE = 3, SG = 1;
`ifdef USB_TX_HANDSHAKE_EN
  localparam int NPKT = 3;
`else
  localparam int NPKT = 2;
`endif

  logic       clk = 1'b0;
  logic       n_rst, start, start_s, abort;
  logic [3:0] token_pid;
  logic       field_done = 1'b0, field_done_s = 1'b0;
  logic       seen_m = 1'b0, seen_s = 1'b0;
  logic       busy, load_en, data_toggle, done;
  logic [2:0] field_sel;
  logic [7:0] pid_out;
  logic [5:0] byte_idx;
  logic       busy_s, load_en_s, data_toggle_s, done_s;
  logic [2:0] field_sel_s;
  logic [7:0] pid_out_s;
  logic [5:0] byte_idx_s;

  int n_pass = 0, n_total = 0, n_done = 0;
  logic [7:0] exp_pid[$];
  logic [5:0] exp_byte[$];
  logic       exp_tog[$];

  usb_tx_seq #(.DATA_BYTES(N), .EOP_CYCLES(E), .GAP_CYCLES(G)) u_dut (
    .clk(clk), .n_rst(n_rst), .start(start), .token_pid(token_pid), .abort(abort),
    .field_done(field_done), .busy(busy), .field_sel(field_sel), .load_en(load_en),
    .pid_out(pid_out), .byte_idx(byte_idx), .data_toggle(data_toggle), .done(done));

  usb_tx_seq #(.DATA_BYTES(SN), .EOP_CYCLES(SE), .GAP_CYCLES(SG)) u_small (
    .clk(clk), .n_rst(n_rst), .start(start_s), .token_pid(token_pid), .abort(abort),
    .field_done(field_done_s), .busy(busy_s), .field_sel(field_sel_s), .load_en(load_en_s),
    .pid_out(pid_out_s), .byte_idx(byte_idx_s), .data_toggle(data_toggle_s), .done(done_s));

  always #5 clk = ~clk;

  // Shifter model: field_done arrives one cycle after each load_en.
  always @(negedge clk) begin
    field_done   = seen_m;
    seen_m       = load_en;
    field_done_s = seen_s;
    seen_s       = load_en_s;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int latency(input int nb, input int e, input int g);
    int l;
    l = 6 + e + g + 6 + 2 * nb + e + g;
    if (NPKT == 3) l += 4 + e + g;
    return l;
  endfunction

  task automatic push_tx(input logic [3:0] tp, input logic tog);
    exp_pid.push_back({~tp, tp});
    exp_pid.push_back(tog ? 8'h4B : 8'hC3);
    if (NPKT == 3) exp_pid.push_back(8'hD2);
    for (int i = 0; i < N; i++) exp_byte.push_back(6'(i));
    exp_tog.push_back(tog);
  endtask

  task automatic wait_done(input int budget, output int cyc);
    logic found;
    found = 1'b0;
    cyc   = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (busy) cyc++;
      if (done) found = 1'b1;
    end
    check("done_seen", 32'(found), 32'd1);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_pid_q"},  32'(exp_pid.size()),  32'd0);
    check({tag, "_byte_q"}, 32'(exp_byte.size()), 32'd0);
    check({tag, "_tog_q"},  32'(exp_tog.size()),  32'd0);
  endtask

  // Scoreboard monitor for the default-parameter instance.
  always @(negedge clk) begin
    if (n_rst && load_en && field_sel == 3'd2) begin
      check("pid_pending", 32'(exp_pid.size() != 0), 32'd1);
      if (exp_pid.size() != 0) check("pid_out", 32'(pid_out), 32'(exp_pid.pop_front()));
    end
    if (n_rst && load_en && field_sel == 3'd4) begin
      check("byte_pending", 32'(exp_byte.size() != 0), 32'd1);
      if (exp_byte.size() != 0) check("byte_idx", 32'(byte_idx), 32'(exp_byte.pop_front()));
    end
    if (n_rst && done) begin
      n_done++;
      check("done_in_gap", 32'(field_sel), 32'd0);
      check("done_pending", 32'(exp_tog.size() != 0), 32'd1);
      if (exp_tog.size() != 0) check("done_toggle", 32'(data_toggle), 32'(exp_tog.pop_front()));
    end
  end

  initial begin
    int   cyc, run, loads, eop_runs, gaps, pid_loads;
    logic found;
    n_rst = 1'b1; start = 1'b0; start_s = 1'b0; abort = 1'b0; token_pid = 4'h0;
    #2 n_rst = 1'b0;
    #10;
    check("rst_busy",   32'(busy),        32'd0);
    check("rst_sel",    32'(field_sel),   32'd0);
    check("rst_load",   32'(load_en),     32'd0);
    check("rst_pid",    32'(pid_out),     32'd0);
    check("rst_byte",   32'(byte_idx),    32'd0);
    check("rst_toggle", 32'(data_toggle), 32'd0);
    check("rst_done",   32'(done),        32'd0);
    @(negedge clk); n_rst = 1'b1;

    // Single transaction with token PID 1.
    token_pid = 4'h1;
    push_tx(4'h1, 1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("tx1_busy", 32'(busy), 32'd1);
    check("tx1_sel",  32'(field_sel), 32'd1);
    check("tx1_load", 32'(load_en), 32'd1);
    wait_done(200, cyc);
    check("tx1_latency", 32'(cyc + 1), 32'(latency(N, E, G)));
    @(negedge clk);
    check("tx1_idle",   32'(busy), 32'd0);
    check("tx1_toggle", 32'(data_toggle), 32'd1);
    check("tx1_ndone",  32'(n_done), 32'd1);
    check_drained("tx1");

    // Back-to-back with start held high; token_pid changes mid-flight for the next one.
    token_pid = 4'h9;
    push_tx(4'h9, 1'b1);
    push_tx(4'hD, 1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    check("tx2_busy", 32'(busy), 32'd1);
    token_pid = 4'hD;
    wait_done(200, cyc);
    check("tx2_latency", 32'(cyc + 1), 32'(latency(N, E, G)));
    @(negedge clk);
    check("b2b_idle",   32'(busy), 32'd0);
    check("tx2_toggle", 32'(data_toggle), 32'd0);
    @(negedge clk);
    check("b2b_restart", 32'(busy), 32'd1);
    check("b2b_sel",     32'(field_sel), 32'd1);
    start = 1'b0;
    wait_done(200, cyc);
    check("tx3_latency", 32'(cyc + 1), 32'(latency(N, E, G)));
    @(negedge clk);
    check("tx3_toggle", 32'(data_toggle), 32'd1);
    check("tx3_ndone",  32'(n_done), 32'd3);
    check_drained("tx3");

    // Abort during data byte 3.
    token_pid = 4'h1;
    exp_pid.push_back(8'hE1);
    exp_pid.push_back(8'h4B);
    for (int i = 0; i < 4; i++) exp_byte.push_back(6'(i));
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (load_en && field_sel == 3'd4 && byte_idx == 6'd3) found = 1'b1;
    end
    check("abort_reach", 32'(found), 32'd1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_busy",   32'(busy), 32'd0);
    check("abort_sel",    32'(field_sel), 32'd0);
    check("abort_byte",   32'(byte_idx), 32'd0);
    check("abort_toggle", 32'(data_toggle), 32'd1);
    check("abort_done",   32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_ndone", 32'(n_done), 32'd3);
    check_drained("abort");

    // Reset mid-transaction clears toggle and gives no done.
    exp_pid.push_back(8'hE1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (field_sel == 3'd3) found = 1'b1;
    end
    check("mrst_reach", 32'(found), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    check("mrst_busy",   32'(busy), 32'd0);
    check("mrst_toggle", 32'(data_toggle), 32'd0);
    check("mrst_done",   32'(done), 32'd0);
    check("mrst_load",   32'(load_en), 32'd0);
    @(negedge clk); n_rst = 1'b1;
    check("mrst_ndone", 32'(n_done), 32'd3);
    check_drained("mrst");

    // Small instance: one data byte, 3-cycle EOPs, 1-cycle gaps.
    cyc = 0; run = 0; loads = 0; eop_runs = 0; gaps = 0; pid_loads = 0; found = 1'b0;
    @(negedge clk); start_s = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (busy_s) cyc++;
      if (load_en_s && field_sel_s == 3'd4) begin
        loads++;
        check("s_byte_idx", 32'(byte_idx_s), 32'd0);
      end
      if (load_en_s && field_sel_s == 3'd2) begin
        pid_loads++;
        check("s_pid_compl", 32'(pid_out_s[7:4] ^ pid_out_s[3:0]), 32'hF);
      end
      if (field_sel_s == 3'd6) run++;
      else if (run != 0) begin
        check("s_eop_len", 32'(run), 32'(SE));
        eop_runs++;
        run = 0;
      end
      if (busy_s && field_sel_s == 3'd0) gaps++;
      if (done_s) found = 1'b1;
    end
    check("s_done_seen", 32'(found), 32'd1);
    check("s_latency",   32'(cyc), 32'(latency(SN, SE, SG)));
    check("s_loads",     32'(loads), 32'd1);
    check("s_pid_loads", 32'(pid_loads), 32'(NPKT));
    check("s_eop_runs",  32'(eop_runs), 32'(NPKT));
    check("s_gaps",      32'(gaps), 32'(NPKT * SG));
    @(negedge clk);
    check("s_toggle", 32'(data_toggle_s), 32'd1);
    check("s_idle",   32'(busy_s), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
